// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART word packer
//
// Holds the packer FSM state encoding and the default end-of-load word.
// No ports.
package uart_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        HOLD    = 2'b01,
        DONE    = 2'b10
    } state_e;

    localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_timeout_cnt.sv
// rtl/uart_timeout_cnt.sv - inter-byte silence counter for the UART word packer
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : a byte arrived this cycle; restart the count
//   enable     : a partial word is held; count while high, sit at 0 otherwise
//   hit        : the silence has lasted TIMEOUT_CYCLES cycles (combinational)
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q counts completed silent cycles; the edge that registers the hit
    // is the TIMEOUT_CYCLES-th one after the last byte.
    assign hit = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART receive bytes into little-endian words
//
// Optional feature macro: UART_PACKER_TIMEOUT_EN (inter-byte timeout that
// discards a stale partial word and pulses timeout_err).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_done_tick : one-cycle strobe, rx_data holds a new byte
//   rx_data      : received byte
//   word_ready   : consumer accepts word_data this cycle
//   word_valid   : word_data/word_addr valid, held until accepted
//   word_data    : assembled word, zero above BYTES_PER_WORD*8 bits
//   word_addr    : index of the presented word, wraps at 2^ADDR_W
//   load_done    : sticky, the END_WORD was accepted
//   overrun      : sticky, a byte arrived while a word was pending
//   timeout_err  : one-cycle pulse, a partial word was discarded
module uart_word_packer import uart_pkg::*; #(
    parameter int          BYTES_PER_WORD = 4,
    parameter int          ADDR_W         = 8,
    parameter logic [31:0] END_WORD       = END_WORD_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    input  logic              word_ready,
    output logic              word_valid,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              load_done,
    output logic              overrun,
    output logic              timeout_err
);

    if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_word_packer: BYTES_PER_WORD must be 1..4 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              load_done_q, load_done_d;
    logic              overrun_q, overrun_d;
    logic              take_byte;

`ifdef UART_PACKER_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;
    logic timeout_hit;

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rx_done_tick),
        .enable((state_q == COLLECT) && (byte_idx_q != 2'd0)),
        .hit   (timeout_hit)
    );

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        load_done_d = load_done_q;
        overrun_d   = overrun_q;
        take_byte   = 1'b0;
`ifdef UART_PACKER_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            COLLECT: begin
                if (rx_done_tick) begin
                    take_byte = 1'b1;
`ifdef UART_PACKER_TIMEOUT_EN
                end else if (timeout_hit) begin
                    byte_idx_d    = 2'd0;
                    word_d        = '0;
                    timeout_err_d = 1'b1;
`endif
                end
            end
            HOLD: begin
                if (valid_q && word_ready) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + 1'b1;
                    if (word_q == END_WORD) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        // A byte landing on the handshake edge starts the next word.
                        take_byte = rx_done_tick;
                    end
                end else if (rx_done_tick) begin
                    overrun_d = 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // byte_idx_q is 0 whenever HOLD is left, so the HOLD path lands here as byte 0.
        if (take_byte) begin
            if (byte_idx_q == 2'd0) begin
                word_d = {24'd0, rx_data};
            end else begin
                word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
            end
            if (byte_idx_q == LAST_IDX) begin
                state_d    = HOLD;
                valid_d    = 1'b1;
                byte_idx_d = 2'd0;
            end else begin
                state_d    = COLLECT;
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            byte_idx_q  <= 2'd0;
            word_q      <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            load_done_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PACKER_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            load_done_q <= load_done_d;
            overrun_q   <= overrun_d;
`ifdef UART_PACKER_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign word_valid = valid_q;
    assign word_data  = word_q;
    assign word_addr  = addr_q;
    assign load_done  = load_done_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/uart_word_packer.md
UART_WORD_PACKER -- requirements
Module: uart_word_packer

Interface
REQ-001 Parameter BYTES_PER_WORD, default 4: bytes assembled per output word; legal values 1..4.
REQ-002 Parameter ADDR_W, default 8: width of the word address counter.
REQ-003 Parameter END_WORD, default 32'hFFFF_FFFF: word value that terminates a load.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000: inter-byte timeout in clk cycles; used only with the macro in REQ-024.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 rx_done_tick  input  1  one-cycle pulse: rx_data holds a new byte.
REQ-008 rx_data  input  8  received byte; sampled only when rx_done_tick=1.
REQ-009 word_ready  input  1  consumer can accept word_data.
REQ-010 word_valid  output  1  word_data and word_addr are valid.
REQ-011 word_data  output  32  assembled word, zero-extended above BYTES_PER_WORD*8 bits.
REQ-012 word_addr  output  ADDR_W  index of the presented word.
REQ-013 load_done  output  1  sticky: END_WORD has been accepted.
REQ-014 overrun  output  1  sticky: a byte was dropped.
REQ-015 timeout_err  output  1  one-cycle pulse: a partial word was discarded.

Function
REQ-016 The FSM SHALL have exactly three states: COLLECT, HOLD and DONE.
- COLLECT -> HOLD when byte BYTES_PER_WORD-1 arrives.
- HOLD -> COLLECT on word_valid & word_ready, unless word_data==END_WORD.
- HOLD -> DONE on word_valid & word_ready when word_data==END_WORD.
- DONE is exited only by reset.
REQ-017 Byte k of a word (k=0 is first received) SHALL be stored at bits [8k+7:8k] (little-endian, byte-serial).
REQ-018 word_valid SHALL assert on the cycle after the rx_done_tick that completes a word (latency 1 clk).
REQ-019 While word_valid=1, word_data and word_addr SHALL remain stable until the handshake.
REQ-020 word_addr SHALL increment by 1 on each handshake and wrap from 2^ADDR_W-1 to 0.
REQ-021 rx_done_tick in HOLD without a same-cycle handshake SHALL drop the byte and set overrun.
REQ-022 rx_done_tick in the same cycle as a HOLD handshake SHALL be stored as byte 0 of the next word; overrun is not set.
REQ-023 rx_done_tick in DONE SHALL be ignored and SHALL NOT set overrun.

Configuration
REQ-024 Macro UART_PACKER_TIMEOUT_EN, when defined:
- In COLLECT with 1..BYTES_PER_WORD-1 bytes held, a counter SHALL count clk cycles since the last byte.
- When the counter reaches TIMEOUT_CYCLES, the partial bytes are discarded, the byte index returns to 0, and timeout_err pulses for 1 cycle.
- Any rx_done_tick resets the counter.
REQ-025 Macro undefined: partial words SHALL be held indefinitely, timeout_err SHALL be tied to 0, and no counter logic exists.

Reset
REQ-026 rst_n=0 SHALL asynchronously force:
- the state to COLLECT, the byte index to 0 and the word register to 0;
- word_addr, word_valid, load_done, overrun and timeout_err to 0;
- the timeout counter to 0.
REQ-027 Reset asserted mid-word or during HOLD SHALL discard all partial or pending data; no word is presented after release.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state encoding (COLLECT=2'b00, HOLD=2'b01, DONE=2'b10) and the END_WORD default constant.
REQ-029 The timeout counter SHALL be a sub-module uart_timeout_cnt, instantiated only under UART_PACKER_TIMEOUT_EN.

Verification
REQ-030 Bytes 0x13,0x00,0x08,0x20 with word_ready=1 -> word_valid 1 clk after the 4th tick, word_data=0x2008_0013, word_addr=0, then word_addr=1.
REQ-031 word_ready=0 held for 3 word periods while 2 further bytes arrive -> word_data stable, overrun=1; after word_ready=1, the next word starts clean.
REQ-032 Bytes FF,FF,FF,FF accepted -> load_done=1 and stays 1; subsequent bytes change no output.
REQ-033 With ADDR_W=2, send 5 words -> word_addr sequence 0,1,2,3,0.
REQ-034 UART_PACKER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, 2 bytes then silence -> timeout_err pulses at 100 clk; next 4 bytes form a full word with byte 0 = first new byte.
REQ-035 Assert rst_n=0 after byte 2 -> all outputs 0 asynchronously; after release, 4 bytes produce a word at word_addr=0.
